// File: rtl/display_pkg.sv
// display_pkg: 720p timing defaults, coordinate width and colour-source mode encoding
// shared by the display timing controller and its axis counters.
package display_pkg;

    localparam int COORD_W = 16;

    localparam int   H_RES  = 1280;
    localparam int   V_RES  = 720;
    localparam int   H_FP   = 110;
    localparam int   H_SYNC = 40;
    localparam int   H_BP   = 220;
    localparam int   V_FP   = 5;
    localparam int   V_SYNC = 5;
    localparam int   V_BP   = 20;
    localparam logic H_POL  = 1'b1;
    localparam logic V_POL  = 1'b1;

    localparam int H_STA = -(H_FP + H_SYNC + H_BP);
    localparam int V_STA = -(V_FP + V_SYNC + V_BP);

    typedef enum logic [1:0] {
        MODE_TEST_CARD = 2'd0,
        MODE_MANDEL    = 2'd1,
        MODE_BLANK     = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    // True when a signed coordinate lies inside the inclusive range [lo, hi]
    function automatic logic in_window(input logic signed [COORD_W-1:0] v,
                                       input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/display_axis_counter.sv
// display_axis_counter: signed coordinate counter running STA..END and folding back
// to STA. Exposes the registered value, the value it will take next, and a wrap flag.
module display_axis_counter
    import display_pkg::*;
#(
    parameter int STA = H_STA,
    parameter int END = H_RES - 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_inc,
    output logic signed [COORD_W-1:0] o_value,
    output logic signed [COORD_W-1:0] o_next,
    output logic                      o_wrap
);

    localparam logic signed [COORD_W-1:0] STA_C = COORD_W'(STA);
    localparam logic signed [COORD_W-1:0] END_C = COORD_W'(END);

    logic signed [COORD_W-1:0] value_q;
    logic signed [COORD_W-1:0] value_d;
    logic                      at_end;

    // Step by one when enabled, returning to the start value after the last one
    always_comb begin
        at_end  = (value_q == END_C);
        value_d = value_q;
        if (i_inc) begin
            value_d = at_end ? STA_C : value_q + COORD_W'(1);
        end
    end

    // Coordinate register, parked at the start value during reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            value_q <= STA_C;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_value = value_q;
    assign o_next  = value_d;
    assign o_wrap  = i_inc & at_end;

endmodule

// File: rtl/display_timing_ctrl.sv
// display_timing_ctrl: pixel-clock timing generator (coordinates, syncs, data enable,
// line/frame strobes) plus a frame-synchronous colour-source mode scheduler.
// Optional macro DISPLAY_TIMING_FRAME_CNT_EN adds the o_frame_cnt frame counter port.
module display_timing_ctrl
    import display_pkg::*;
#(
    parameter int   H_RES  = display_pkg::H_RES,
    parameter int   V_RES  = display_pkg::V_RES,
    parameter int   H_FP   = display_pkg::H_FP,
    parameter int   H_SYNC = display_pkg::H_SYNC,
    parameter int   H_BP   = display_pkg::H_BP,
    parameter int   V_FP   = display_pkg::V_FP,
    parameter int   V_SYNC = display_pkg::V_SYNC,
    parameter int   V_BP   = display_pkg::V_BP,
    parameter logic H_POL  = display_pkg::H_POL,
    parameter logic V_POL  = display_pkg::V_POL
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [1:0]                             i_mode_req,
    input  logic                                   i_mode_valid,
    output logic [1:0]                             o_mode,
    output logic                                   o_mode_busy,
    output logic                                   o_mode_ack,
    output logic                                   o_mode_err,
    output logic signed [display_pkg::COORD_W-1:0] o_sx,
    output logic signed [display_pkg::COORD_W-1:0] o_sy,
    output logic                                   o_hsync,
    output logic                                   o_vsync,
    output logic                                   o_de,
    output logic                                   o_frame,
    output logic                                   o_line
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]                            o_frame_cnt
`endif
);

    localparam int H_START = -(H_FP + H_SYNC + H_BP);
    localparam int V_START = -(V_FP + V_SYNC + V_BP);
    localparam int HS_ON   = H_START + H_FP;
    localparam int HS_OFF  = HS_ON + H_SYNC - 1;
    localparam int VS_ON   = V_START + V_FP;
    localparam int VS_OFF  = VS_ON + V_SYNC - 1;

    logic signed [COORD_W-1:0] sx;
    logic signed [COORD_W-1:0] sy;
    logic signed [COORD_W-1:0] sx_next;
    logic signed [COORD_W-1:0] sy_next;
    logic                      h_wrap;
    logic                      v_wrap;

    logic  hsync_q, hsync_d;
    logic  vsync_q, vsync_d;
    logic  de_q, de_d;
    logic  line_q, line_d;
    logic  frame_q, frame_d;
    mode_e mode_q, mode_d;
    mode_e pending_q, pending_d;
    logic  busy_q, busy_d;
    logic  ack_q, ack_d;
    logic  err_q, err_d;

    display_axis_counter #(
        .STA (H_START),
        .END (H_RES - 1)
    ) u_h_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (1'b1),
        .o_value (sx),
        .o_next  (sx_next),
        .o_wrap  (h_wrap)
    );

    display_axis_counter #(
        .STA (V_START),
        .END (V_RES - 1)
    ) u_v_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (h_wrap),
        .o_value (sy),
        .o_next  (sy_next),
        .o_wrap  (v_wrap)
    );

    // Decode the upcoming coordinates so registered strobes line up with o_sx/o_sy
    always_comb begin
        hsync_d = in_window(sx_next, HS_ON, HS_OFF) ? H_POL : ~H_POL;
        vsync_d = in_window(sy_next, VS_ON, VS_OFF) ? V_POL : ~V_POL;
        de_d    = ~sx_next[COORD_W-1] & ~sy_next[COORD_W-1];
        line_d  = h_wrap;
        frame_d = v_wrap;
    end

    // Mode scheduler: hold the latest legal request, swap it in only on a frame strobe
    always_comb begin
        mode_d    = mode_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        if (frame_d && busy_q) begin
            mode_d = pending_q;
            ack_d  = 1'b1;
            busy_d = 1'b0;
        end
        if (i_mode_valid) begin
            if (mode_e'(i_mode_req) == MODE_RSVD) begin
                err_d = 1'b1;
            end else begin
                pending_d = mode_e'(i_mode_req);
                busy_d    = 1'b1;
            end
        end
    end

    // Output and scheduler registers; reset discards any pending request
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hsync_q   <= ~H_POL;
            vsync_q   <= ~V_POL;
            de_q      <= 1'b0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            mode_q    <= MODE_TEST_CARD;
            pending_q <= MODE_TEST_CARD;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter advances together with the frame strobe, wrapping naturally
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

    assign o_sx        = sx;
    assign o_sy        = sy;
    assign o_hsync     = hsync_q;
    assign o_vsync     = vsync_q;
    assign o_de        = de_q;
    assign o_line      = line_q;
    assign o_frame     = frame_q;
    assign o_mode      = mode_q;
    assign o_mode_busy = busy_q;
    assign o_mode_ack  = ack_q;
    assign o_mode_err  = err_q;

endmodule

// File: tb/tb_display_timing_ctrl.sv
// tb_display_timing_ctrl: directed bench. A shrunken-timing instance (16x8 active,
// 25x14 total, 350-cycle frame, active-low vsync) carries the frame and mode tests;
// a default 720p instance is checked over its first full line.
`timescale 1ns/1ps
module tb_display_timing_ctrl;
    import display_pkg::*;

    // Hand-computed figures for the shrunken timing
    localparam int S_H_STA = -9;
    localparam int S_V_STA = -6;
    localparam int S_H_TOT = 25;
    localparam int S_FRAME = 350;

    logic        clk;
    logic        rst;
    logic [1:0]  mode_req;
    logic        mode_valid;

    logic [1:0]         mode;
    logic               busy, ack, err;
    logic signed [15:0] sx, sy;
    logic               hsync, vsync, de, frame, line;

    logic [1:0]         d_mode;
    logic               d_busy, d_ack, d_err;
    logic signed [15:0] d_sx, d_sy;
    logic               d_hsync, d_vsync, d_de, d_frame, d_line;
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    logic [15:0]        frame_cnt, d_frame_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int n = 0;
    bit track = 0;
    bit post_rst = 0;
    int ack_seen = 0;
    int err_seen = 0;
    int mode_changes = 0;
    logic [1:0] prev_mode = 2'd0;
    int de_cnt = 0;
    int vs_cnt = 0;
    int d_line_cnt = 0;
    int d_hs_cnt = 0;
    int d_hs_first = 9999;
    int ack_base;

    display_timing_ctrl #(
        .H_RES (16), .V_RES (8),
        .H_FP (2), .H_SYNC (3), .H_BP (4),
        .V_FP (1), .V_SYNC (2), .V_BP (3),
        .H_POL (1'b1), .V_POL (1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mode_req   (mode_req),
        .i_mode_valid (mode_valid),
        .o_mode       (mode),
        .o_mode_busy  (busy),
        .o_mode_ack   (ack),
        .o_mode_err   (err),
        .o_sx         (sx),
        .o_sy         (sy),
        .o_hsync      (hsync),
        .o_vsync      (vsync),
        .o_de         (de),
        .o_frame      (frame),
        .o_line       (line)
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        ,
        .o_frame_cnt  (frame_cnt)
`endif
    );

    display_timing_ctrl dut_dflt (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mode_req   (2'd0),
        .i_mode_valid (1'b0),
        .o_mode       (d_mode),
        .o_mode_busy  (d_busy),
        .o_mode_ack   (d_ack),
        .o_mode_err   (d_err),
        .o_sx         (d_sx),
        .o_sy         (d_sy),
        .o_hsync      (d_hsync),
        .o_vsync      (d_vsync),
        .o_de         (d_de),
        .o_frame      (d_frame),
        .o_line       (d_line)
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        ,
        .o_frame_cnt  (d_frame_cnt)
`endif
    );

    // Free-running pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d, t=%0t)",
                     tag, observed, expected, n, $time);
        end
    endtask

    // Reference timing computed from the cycle index by modular arithmetic
    task automatic checkTiming();
        int pos, esx, esy;
        pos = n % S_FRAME;
        esx = S_H_STA + (pos % S_H_TOT);
        esy = S_V_STA + (pos / S_H_TOT);
        checkOutput("sx", int'(sx), esx);
        checkOutput("sy", int'(sy), esy);
        checkOutput("hsync", int'(hsync), (esx >= -7 && esx <= -5) ? 1 : 0);
        checkOutput("vsync", int'(vsync), (esy >= -5 && esy <= -4) ? 0 : 1);
        checkOutput("de", int'(de), (esx >= 0 && esy >= 0) ? 1 : 0);
        checkOutput("line", int'(line), (n > 0 && esx == S_H_STA) ? 1 : 0);
        checkOutput("frame", int'(frame), (n > 0 && pos == 0) ? 1 : 0);
    endtask

    task automatic tick();
        @(negedge clk);
        n++;
        if (ack) ack_seen++;
        if (err) err_seen++;
        if (mode != prev_mode) mode_changes++;
        prev_mode = mode;
        if (!post_rst && n <= S_FRAME) begin
            if (de) de_cnt++;
            if (!vsync) vs_cnt++;
        end
        if (!post_rst && n <= 1650) begin
            if (d_line) d_line_cnt++;
            if (d_hsync) begin
                d_hs_cnt++;
                if (d_hs_first == 9999) d_hs_first = int'(d_sx);
            end
        end
        if (track) checkTiming();
    endtask

    task automatic runTo(input int target);
        while (n < target) tick();
    endtask

    task automatic applyStimulus(input logic [1:0] req);
        mode_req   = req;
        mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        mode_req   = 2'd0;
    endtask

    initial begin
        rst = 1'b1;
        mode_req = 2'd0;
        mode_valid = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_sx", int'(sx), -9);
        checkOutput("rst_sy", int'(sy), -6);
        checkOutput("rst_hsync", int'(hsync), 0);
        checkOutput("rst_vsync", int'(vsync), 1);
        checkOutput("rst_de", int'(de), 0);
        checkOutput("rst_frame", int'(frame), 0);
        checkOutput("rst_line", int'(line), 0);
        checkOutput("rst_mode", int'(mode), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_ack", int'(ack), 0);
        checkOutput("rst_err", int'(err), 0);
        checkOutput("dflt_rst_sx", int'(d_sx), -370);
        checkOutput("dflt_rst_sy", int'(d_sy), -30);
        checkOutput("dflt_rst_hsync", int'(d_hsync), 0);
        checkOutput("dflt_rst_vsync", int'(d_vsync), 0);
        checkOutput("dflt_rst_frame", int'(d_frame), 0);

        rst = 1'b0;
        track = 1'b1;
        checkTiming();

        runTo(S_FRAME);
        checkOutput("first_frame", int'(frame), 1);
        checkOutput("de_per_frame", de_cnt, 128);
        checkOutput("vsync_cycles", vs_cnt, 50);

        runTo(600);
        applyStimulus(MODE_MANDEL);
        checkOutput("A_busy_set", int'(busy), 1);
        checkOutput("A_mode_held", int'(mode), 0);
        runTo(699);
        checkOutput("A_busy_before_frame", int'(busy), 1);
        checkOutput("A_mode_before_frame", int'(mode), 0);
        checkOutput("A_no_early_ack", ack_seen, 0);
        tick();
        checkOutput("A_frame", int'(frame), 1);
        checkOutput("A_mode_applied", int'(mode), 1);
        checkOutput("A_ack", int'(ack), 1);
        checkOutput("A_busy_clear", int'(busy), 0);
        tick();
        checkOutput("A_ack_pulse", int'(ack), 0);

        ack_base = ack_seen;
        runTo(710);
        applyStimulus(MODE_MANDEL);
        runTo(720);
        applyStimulus(MODE_BLANK);
        checkOutput("B_busy", int'(busy), 1);
        checkOutput("B_mode_held", int'(mode), 1);
        runTo(1050);
        checkOutput("B_mode_last_wins", int'(mode), 2);
        checkOutput("B_ack", int'(ack), 1);
        checkOutput("B_busy_clear", int'(busy), 0);
        checkOutput("B_single_ack", ack_seen - ack_base, 1);

        runTo(1060);
        applyStimulus(MODE_RSVD);
        checkOutput("C_err", int'(err), 1);
        checkOutput("C_busy", int'(busy), 0);
        checkOutput("C_mode", int'(mode), 2);
        tick();
        checkOutput("C_err_pulse", int'(err), 0);
        checkOutput("C_err_count", err_seen, 1);

        runTo(1399);
        applyStimulus(MODE_TEST_CARD);
        checkOutput("D_frame", int'(frame), 1);
        checkOutput("D_no_ack", int'(ack), 0);
        checkOutput("D_mode_kept", int'(mode), 2);
        checkOutput("D_busy", int'(busy), 1);
        runTo(1650);
        checkOutput("dflt_line_sx", int'(d_sx), -370);
        checkOutput("dflt_line_sy", int'(d_sy), -29);
        checkOutput("dflt_line_strobe", int'(d_line), 1);
        checkOutput("dflt_line_count", d_line_cnt, 1);
        checkOutput("dflt_hsync_len", d_hs_cnt, 40);
        checkOutput("dflt_hsync_start", d_hs_first, -260);
        runTo(1749);
        checkOutput("D_mode_stable", mode_changes, 2);
        tick();
        checkOutput("D_mode_applied", int'(mode), 0);
        checkOutput("D_ack", int'(ack), 1);
        checkOutput("D_busy_clear", int'(busy), 0);

        runTo(1760);
        applyStimulus(MODE_MANDEL);
        checkOutput("E_busy", int'(busy), 1);
        runTo(2064);
        checkOutput("E_sx_mid", int'(sx), 5);
        rst = 1'b1;
        track = 1'b0;
        post_rst = 1'b1;
        ack_base = ack_seen;
        tick();
        checkOutput("E_rst_sx", int'(sx), -9);
        checkOutput("E_rst_sy", int'(sy), -6);
        checkOutput("E_rst_mode", int'(mode), 0);
        checkOutput("E_rst_busy", int'(busy), 0);
        checkOutput("E_rst_ack", int'(ack), 0);
        checkOutput("E_rst_frame", int'(frame), 0);
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        checkOutput("E_rst_frame_cnt", int'(frame_cnt), 0);
`endif
        rst = 1'b0;
        n = 0;
        track = 1'b1;
        checkTiming();
        runTo(3 * S_FRAME);
        checkOutput("E_mode_after", int'(mode), 0);
        checkOutput("E_busy_after", int'(busy), 0);
        checkOutput("E_no_ack", ack_seen - ack_base, 0);
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        checkOutput("E_frame_cnt", int'(frame_cnt), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
